// File: rtl/nibble_add_arbiter_if.sv
// Request/result bundle for nibble_add_arbiter: NREQ request ports and one result port.
interface nibble_add_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [4:0]        res_sum;
  logic [TAG_W-1:0]  res_tag;
  logic              res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_sum, res_tag
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_sum, res_tag
  );
endinterface

// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter sharing one registered nibble adder (A=[7:4], B=[3:0]) among NREQ requesters.
module nibble_add_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_add_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     ops_done,
  output logic                 busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TAG_W-1:0] r_ptr;
  logic [TAG_W-1:0] w_ptr_nxt;
  logic [TAG_W-1:0] r_tag;
  logic [4:0]       r_sum;
  logic [CNT_W-1:0] r_ops;
  logic             w_can_accept;
  logic             w_gnt_any;
  logic [TAG_W-1:0] w_gnt_idx;
  logic [7:0]       w_gnt_data;
  logic [NREQ-1:0]  w_ready;
  logic             w_drain;

  assign w_drain = (r_state == FULL) && bus.res_ready;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    w_gnt_any    = 1'b0;
    w_gnt_idx    = '0;
    w_gnt_data   = '0;
    w_ready      = '0;
    w_ptr_nxt    = r_ptr;
    w_can_accept = (r_state == EMPTY) || bus.res_ready;
    if (rst_n && w_can_accept) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (int'(r_ptr) + k) % NREQ;
        if (!w_gnt_any && bus.req_valid[idx]) begin
          w_gnt_any    = 1'b1;
          w_gnt_idx    = TAG_W'(idx);
          w_gnt_data   = bus.req_data[8*idx +: 8];
          w_ready[idx] = 1'b1;
          w_ptr_nxt    = (idx == NREQ - 1) ? '0 : TAG_W'(idx + 1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_gnt_any) w_state_nxt = FULL;
      FULL:    if (bus.res_ready && !w_gnt_any) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_tag   <= '0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_gnt_any) begin
        r_sum <= {1'b0, w_gnt_data[7:4]} + {1'b0, w_gnt_data[3:0]};
        r_tag <= w_gnt_idx;
      end
      if (w_drain) r_ops <= r_ops + CNT_W'(1);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.res_valid = (r_state == FULL);
  assign bus.res_sum   = r_sum;
  assign bus.res_tag   = r_tag;
  assign ops_done      = r_ops;
  assign busy          = (r_state == FULL) || (|bus.req_valid);

endmodule
